// File: rtl/herald_mac_pkg.sv
// Shared encodings for the Herald MAC datapath: op codes, FSM states, Q12.12 limits.
// The byte-bus front end imports the same op constants.
package herald_mac_pkg;

   localparam int MAC_WIDTH = 24;
   localparam int MAC_FRAC  = 12;

   localparam logic [1:0] OP_MUL = 2'd0;
   localparam logic [1:0] OP_MAC = 2'd1;
   localparam logic [1:0] OP_MSU = 2'd2;
   localparam logic [1:0] OP_CLR = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_ACC  = 2'd2,
      ST_RESP = 2'd3
   } mac_state_t;

   localparam logic [MAC_WIDTH-1:0] SAT_MAX = 24'h7FFFFF;
   localparam logic [MAC_WIDTH-1:0] SAT_MIN = 24'h800000;

   // Half an LSB of the Q12.12 result, added before the arithmetic shift.
   localparam logic [2*MAC_WIDTH-1:0] RND_CONST = (2*MAC_WIDTH)'(1) << (MAC_FRAC - 1);

endpackage

// File: rtl/herald_seq_mult.sv
// Unsigned WIDTH x WIDTH shift-add multiplier, one multiplier bit per cycle, LSB first.
// done pulses for one cycle once all WIDTH steps have been applied.
module herald_seq_mult #(
   parameter int WIDTH = 24
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 start,
   input  logic [WIDTH-1:0]     mcand_in,
   input  logic [WIDTH-1:0]     mplier_in,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [WIDTH:0]     step_sum;

   // Upper half accumulates partial products while the multiplier drains out of the lower half.
   always_comb begin
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
      if (start) begin
         mcand_d = mcand_in;
         prod_d  = {{WIDTH{1'b0}}, mplier_in};
         cnt_d   = CW'(WIDTH);
      end else if (cnt_q != '0) begin
         if (prod_q[0]) begin
            prod_d = {step_sum, prod_q[WIDTH-1:1]};
         end else begin
            prod_d = {1'b0, prod_q[2*WIDTH-1:1]};
         end
         cnt_d  = cnt_q - CW'(1);
         done_d = (cnt_q == CW'(1));
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign done    = done_q;
   assign product = prod_q;

endmodule

// File: rtl/herald_mac_engine.sv
// Q12.12 multiply / MAC / MSU / clear engine with a valid/ready response port.
// Optional sticky saturation flag output ovf when HERALD_MAC_OVF_FLAG_EN is defined.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | ready for a command; CLEAR completes here without a response
//   MUL     | shift-add core running on operand magnitudes
//   ACC     | signed product rounded, combined with acc and saturated
//   RESP    | result held on rsp_data until the consumer takes it
module herald_mac_engine
   import herald_mac_pkg::*;
#(
   parameter int WIDTH = MAC_WIDTH,
   parameter int FRAC  = MAC_FRAC
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             busy
`ifdef HERALD_MAC_OVF_FLAG_EN
   ,
   output logic             ovf
`endif
);

   localparam int PW = 2 * WIDTH;
   localparam int SW = 2 * WIDTH + 1;
   localparam logic signed [PW-1:0] RND    = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam logic signed [SW-1:0] LIM_HI = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] LIM_LO = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

   mac_state_t              state_q, state_d;
   logic [1:0]              op_q, op_d;
   logic                    sign_q, sign_d;
   logic signed [WIDTH-1:0] acc_q, acc_d;
   logic signed [PW-1:0]    p2_q, p2_d;
   logic [WIDTH-1:0]        rsp_data_q, rsp_data_d;
   logic                    rsp_valid_q, rsp_valid_d;

   logic                    accept;
   logic                    mult_start;
   logic                    mult_done;
   logic [PW-1:0]           mult_prod;
   logic [WIDTH-1:0]        mag_a, mag_b;
   logic signed [PW-1:0]    pq;
   logic signed [SW-1:0]    sum;
   logic [WIDTH-1:0]        r;

   assign accept     = cmd_valid && (state_q == ST_IDLE);
   assign mult_start = accept && (cmd_op != OP_CLR);
   // The most negative operand maps to itself, which is still the right unsigned magnitude.
   assign mag_a      = cmd_a[WIDTH-1] ? -cmd_a : cmd_a;
   assign mag_b      = cmd_b[WIDTH-1] ? -cmd_b : cmd_b;

   herald_seq_mult #(.WIDTH(WIDTH)) u_mult (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .start     (mult_start),
      .mcand_in  (mag_a),
      .mplier_in (mag_b),
      .done      (mult_done),
      .product   (mult_prod)
   );

   always_comb begin
      pq = (p2_q + RND) >>> FRAC;
      case (op_q)
         OP_MAC:  sum = SW'(acc_q) + SW'(pq);
         OP_MSU:  sum = SW'(acc_q) - SW'(pq);
         default: sum = SW'(pq);
      endcase
      if (sum > LIM_HI) begin
         r = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (sum < LIM_LO) begin
         r = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         r = sum[WIDTH-1:0];
      end
   end

`ifdef HERALD_MAC_OVF_FLAG_EN
   logic ovf_q, ovf_d;
   logic clamp;
   assign clamp = (sum > LIM_HI) || (sum < LIM_LO);
`endif

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      sign_d      = sign_q;
      acc_d       = acc_q;
      p2_d        = p2_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = rsp_valid_q;
`ifdef HERALD_MAC_OVF_FLAG_EN
      ovf_d       = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (cmd_op == OP_CLR) begin
                  acc_d = '0;
`ifdef HERALD_MAC_OVF_FLAG_EN
                  ovf_d = 1'b0;
`endif
               end else begin
                  op_d    = cmd_op;
                  sign_d  = cmd_a[WIDTH-1] ^ cmd_b[WIDTH-1];
                  state_d = ST_MUL;
               end
            end
         end
         ST_MUL: begin
            if (mult_done) begin
               p2_d    = sign_q ? -$signed(mult_prod) : $signed(mult_prod);
               state_d = ST_ACC;
            end
         end
         ST_ACC: begin
            rsp_data_d  = r;
            rsp_valid_d = 1'b1;
            if ((op_q == OP_MAC) || (op_q == OP_MSU)) begin
               acc_d = $signed(r);
            end
`ifdef HERALD_MAC_OVF_FLAG_EN
            ovf_d = ovf_q | clamp;
`endif
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_MUL;
         sign_q      <= 1'b0;
         acc_q       <= '0;
         p2_q        <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
`ifdef HERALD_MAC_OVF_FLAG_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         sign_q      <= sign_d;
         acc_q       <= acc_d;
         p2_q        <= p2_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
`ifdef HERALD_MAC_OVF_FLAG_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign rsp_data  = rsp_data_q;
   assign rsp_valid = rsp_valid_q;
`ifdef HERALD_MAC_OVF_FLAG_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_herald_mac_engine.sv
// Scoreboard bench for herald_mac_engine: directed commands push expected results,
// a negedge monitor pops and compares data and latency on each new response.
module tb_herald_mac_engine;
   import herald_mac_pkg::*;

   localparam int W   = 24;
   localparam int LAT = W + 2;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [1:0]    cmd_op = 2'd0;
   logic [W-1:0]  cmd_a = '0;
   logic [W-1:0]  cmd_b = '0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [W-1:0]  rsp_data;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic          busy;
`ifdef HERALD_MAC_OVF_FLAG_EN
   logic          ovf;
`endif

   herald_mac_engine dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .rsp_data  (rsp_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .busy      (busy)
`ifdef HERALD_MAC_OVF_FLAG_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [W-1:0] exp_data_q[$];
   int           exp_cyc_q[$];
   string        exp_name_q[$];

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%06h, expected 0x%06h", name, act, exp);
      end
   endtask

   // Monitor: each rising rsp_valid is one response.
   logic         prev_valid = 1'b0;
   logic [W-1:0] m_data;
   int           m_cyc;
   string        m_name;
   always @(negedge CLK) begin
      if (rsp_valid && !prev_valid) begin
         if (exp_data_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got data 0x%06h, expected no response", rsp_data);
         end else begin
            m_data = exp_data_q.pop_front();
            m_cyc  = exp_cyc_q.pop_front();
            m_name = exp_name_q.pop_front();
            check({m_name, "_data"}, rsp_data, m_data);
            check({m_name, "_latency"}, W'(cyc - m_cyc), W'(LAT));
         end
      end
      prev_valid <= rsp_valid;
   end

   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input bit want_rsp, input string name);
      int guard;
      guard = 0;
      @(negedge CLK);
      while (!cmd_ready && guard < 200) begin
         @(negedge CLK);
         guard++;
      end
      if (!cmd_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: cmd_ready stayed 0, expected 1", name);
         return;
      end
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_valid = 1'b1;
      @(posedge CLK);
      #1;
      if (want_rsp && op != OP_CLR) begin
         exp_data_q.push_back(exp);
         exp_cyc_q.push_back(cyc);
         exp_name_q.push_back(name);
      end
      cmd_valid = 1'b0;
      cmd_a     = W'($urandom());
      cmd_b     = W'($urandom());
   endtask

   task automatic wait_idle(input string name);
      int guard;
      guard = 0;
      @(negedge CLK);
      while ((busy || exp_data_q.size() != 0) && guard < 300) begin
         @(negedge CLK);
         guard++;
      end
      if (busy || exp_data_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_idle_timeout: busy=%0d pending=%0d, expected 0 and 0", name, busy, exp_data_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      repeat (3) @(negedge CLK);
      check("rst_rsp_valid", W'(rsp_valid), W'(0));
      check("rst_rsp_data",  rsp_data, W'(0));
      check("rst_cmd_ready", W'(cmd_ready), W'(1));
      check("rst_busy",      W'(busy), W'(0));
`ifdef HERALD_MAC_OVF_FLAG_EN
      check("rst_ovf", W'(ovf), W'(0));
`endif
      RST_N = 1'b1;

      issue(OP_MUL, 24'h001800, 24'h002000, 24'h003000, 1, "mul_1p5x2");
      wait_idle("mul_1p5x2");
`ifdef HERALD_MAC_OVF_FLAG_EN
      check("ovf_after_plain", W'(ovf), W'(0));
`endif
      issue(OP_CLR, '0, '0, '0, 0, "clr0");
      issue(OP_MAC, 24'h001000, 24'h001000, 24'h001000, 1, "mac1");
      issue(OP_MAC, 24'h001000, 24'h001000, 24'h002000, 1, "mac2");
      issue(OP_MSU, 24'h000800, 24'h001000, 24'h001800, 1, "msu1");
      issue(OP_MUL, 24'hFFF000, 24'h002000, 24'hFFE000, 1, "mul_neg");
      issue(OP_MAC, 24'h001000, 24'h001000, 24'h002800, 1, "mac_after_mul");

      issue(OP_MUL, 24'h7FFFFF, 24'h7FFFFF, SAT_MAX, 1, "sat_pp");
      issue(OP_MUL, 24'h800000, 24'h7FFFFF, SAT_MIN, 1, "sat_np");
      issue(OP_MUL, 24'h800000, 24'h800000, SAT_MAX, 1, "sat_nn");
      wait_idle("sat_mul");
`ifdef HERALD_MAC_OVF_FLAG_EN
      check("ovf_after_sat", W'(ovf), W'(1));
`endif
      issue(OP_MAC, 24'h7FFFFF, 24'h001000, SAT_MAX, 1, "mac_sat");
      issue(OP_MSU, 24'h001000, 24'h001000, 24'h7FEFFF, 1, "msu_after_sat");
      wait_idle("acc_sat");
`ifdef HERALD_MAC_OVF_FLAG_EN
      check("ovf_sticky", W'(ovf), W'(1));
`endif
      issue(OP_CLR, '0, '0, '0, 0, "clr1");
      @(negedge CLK);
`ifdef HERALD_MAC_OVF_FLAG_EN
      check("ovf_cleared", W'(ovf), W'(0));
`endif
      issue(OP_MSU, 24'h7FFFFF, 24'h7FFFFF, SAT_MIN, 1, "msu_sat_neg");
      issue(OP_CLR, '0, '0, '0, 0, "clr2");

      issue(OP_MUL, 24'h000001, 24'h000800, 24'h000001, 1, "rnd_half_up");
      issue(OP_MUL, 24'hFFFFFF, 24'h000800, 24'h000000, 1, "rnd_neg_half");
      issue(OP_MUL, 24'hFFFFFF, 24'h000400, 24'h000000, 1, "rnd_neg_quarter");
      issue(OP_MUL, 24'hFFFFFF, 24'h000C00, 24'hFFFFFF, 1, "rnd_neg_3q");
      wait_idle("rnd");
`ifdef HERALD_MAC_OVF_FLAG_EN
      check("ovf_after_rnd", W'(ovf), W'(0));
`endif

      // Backpressure: hold the response, try to sneak in a MAC, then release.
      rsp_ready = 1'b0;
      issue(OP_MUL, 24'h001000, 24'h003000, 24'h003000, 1, "bp_mul");
      guard = 0;
      while (!rsp_valid && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         check("bp_data",      rsp_data, 24'h003000);
         check("bp_valid",     W'(rsp_valid), W'(1));
         check("bp_cmd_ready", W'(cmd_ready), W'(0));
         check("bp_busy",      W'(busy), W'(1));
         if (i == 2) begin
            cmd_op    = OP_MAC;
            cmd_a     = 24'h001000;
            cmd_b     = 24'h001000;
            cmd_valid = 1'b1;
         end
         if (i == 5) cmd_valid = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge CLK);
      #1;
      check("bp_valid_drop",  W'(rsp_valid), W'(0));
      check("bp_ready_after", W'(cmd_ready), W'(1));
      issue(OP_MAC, 24'h001000, 24'h001000, 24'h001000, 1, "mac_after_bp");
      wait_idle("bp");

      // Reset ten cycles into a MAC: nothing may come out and acc must be cleared.
      issue(OP_MAC, 24'h001000, 24'h002000, '0, 0, "mac_abort");
      repeat (10) @(posedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      check("midrst_rsp_valid", W'(rsp_valid), W'(0));
      check("midrst_rsp_data",  rsp_data, W'(0));
      check("midrst_cmd_ready", W'(cmd_ready), W'(1));
      check("midrst_busy",      W'(busy), W'(0));
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (40) @(negedge CLK);
      check("post_rst_busy", W'(busy), W'(0));
      issue(OP_MUL, 24'h001800, 24'h002000, 24'h003000, 1, "mul_after_rst");
      issue(OP_MAC, 24'h001000, 24'h001000, 24'h001000, 1, "mac_acc_zero");
      wait_idle("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/herald_mac_engine.md
Name: herald_mac_engine

Overview:
- Fixed-point multiply/accumulate engine that consumes the 24-bit Q12.12 operand pairs collected by the Herald byte-bus front end.
- Performs multiply, MAC, MSU and accumulator clear.
- Uses an iterative shift-add multiplier to keep area small for the TinyTapeout tile.
- Returns one 24-bit result per command through a valid/ready response port.

Parameters:
- WIDTH, 24: operand, accumulator and result width in bits (two's complement).
- FRAC, 12: number of fractional bits (Q(WIDTH-FRAC).FRAC).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- cmd_op  in  2  operation: 0 MULTIPLY, 1 MAC, 2 MSU, 3 CLEAR.
- cmd_a  in  WIDTH  signed operand A.
- cmd_b  in  WIDTH  signed operand B.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine can accept a command.
- rsp_data  out  WIDTH  signed result.
- rsp_valid  out  1  rsp_data is valid.
- rsp_ready  in  1  consumer takes the result.
- busy  out  1  command in flight or response pending.

Behaviour:
- Reset (asynchronous, active-low; all regs cleared immediately):
  - state=IDLE; accumulator=0; rsp_data=0; rsp_valid=0; cmd_ready=1; busy=0.
  - Reset mid-operation abandons the command. No response is issued and accumulator=0.
- States: IDLE, MUL, ACC, RESP.
- cmd_ready=1 only in IDLE. busy = (state != IDLE).
- Accept: cmd_valid && cmd_ready on a rising edge.
  - cmd_a, cmd_b and cmd_op are latched; the bus may change afterwards.
- CLEAR:
  - On accept, accumulator<=0; state stays IDLE.
  - No response is produced. The next command can be accepted on the following edge.
- MULTIPLY/MAC/MSU: IDLE -> MUL.
  - Magnitudes |a| and |b| are taken as WIDTH-bit unsigned. |0x800000| = 0x800000 is valid.
  - Sign = a[W-1]^b[W-1].
  - MUL runs exactly WIDTH cycles, one multiplier bit per cycle, LSB first, producing a 2*WIDTH-bit unsigned product.
  - MUL -> ACC: the product is negated if sign=1, giving signed p2 (Q(2W-2F).2F).
  - Rounding: pq = (p2 + 2^(FRAC-1)) >>> FRAC, i.e. round half toward +inf. pq is kept at 2*WIDTH bits.
  - MULTIPLY: r = sat(pq).
  - MAC: r = sat(acc + pq); acc<=r.
  - MSU: r = sat(acc - pq); acc<=r.
  - sat() clamps to [-2^(W-1), 2^(W-1)-1]: 0x800000..0x7FFFFF.
  - The sum/difference is computed at 2*WIDTH+1 bits before clamping, so it never wraps.
  - ACC -> RESP: rsp_data<=r; rsp_valid<=1.
- Latency: rsp_valid is first high exactly WIDTH+2 rising edges after the accept edge (26 for the default).
- RESP:
  - rsp_data and rsp_valid stay stable until rsp_valid && rsp_ready on an edge, then -> IDLE with rsp_valid<=0.
  - cmd_ready is first high in the cycle after the response handshake. No accept and response in the same cycle.
- cmd_valid outside IDLE is ignored. No queuing.
- MULTIPLY never modifies acc. A saturated MAC/MSU stores the clamped value.

Optional Feature:
- HERALD_MAC_OVF_FLAG_EN defined:
  - Adds output port ovf (1 bit), a sticky flag.
  - Set in ACC whenever sat() clamps (any op). Cleared by CLEAR or reset.
  - Reset value 0.
- Not defined: no ovf port and no flag register. Saturation behaviour is identical.

Decomposition:
- Shared package herald_mac_pkg:
  - op encoding constants (OP_MUL, OP_MAC, OP_MSU, OP_CLR).
  - state encoding.
  - Q12.12 saturation limits (SAT_MAX=0x7FFFFF, SAT_MIN=0x800000).
  - rounding constant.
  - The front end imports the same op constants.
- One sub-module: herald_seq_mult.
  - Unsigned WIDTH x WIDTH shift-add core with start/done.
  - done pulses after exactly WIDTH cycles.
- Sign handling, rounding, saturation and the accumulator stay in herald_mac_engine.

Test Plan:
- MULTIPLY a=0x001800 (1.5), b=0x002000 (2.0) -> rsp_data=0x003000 after exactly 26 edges; acc unchanged (0).
- CLEAR; MAC(0x001000,0x001000) -> 0x001000; MAC again -> 0x002000; MSU(0x000800,0x001000) -> 0x001800.
- Saturation:
  - MULTIPLY 0x7FFFFF*0x7FFFFF -> 0x7FFFFF.
  - 0x800000*0x7FFFFF -> 0x800000.
  - 0x800000*0x800000 -> 0x7FFFFF.
  - With HERALD_MAC_OVF_FLAG_EN, ovf=1 until CLEAR.
- Rounding:
  - 0x000001*0x000800 -> 0x000001.
  - 0xFFFFFF*0x000800 -> 0x000000.
  - 0xFFFFFF*0x000400 -> 0x000000.
- Backpressure: rsp_ready low for 10 cycles -> rsp_data/rsp_valid stable, cmd_ready=0, busy=1; a second cmd_valid is ignored; after the handshake cmd_ready=1 next cycle.
- Reset mid-operation: assert RST_N low at cycle 10 of a MAC -> outputs at reset values immediately, acc=0, no rsp_valid afterwards; next MULTIPLY gives correct result.
